// File: rtl/oh_csa_accum.sv
// oh_csa_accum: multi-operand accumulator that keeps its running total in
// carry-save form, so each operand costs one 3:2 CSA step. A single
// carry-propagate add at the end of a frame produces the final sum.
//
// State table:
//   ST_ACCUM   | taking operands; one CSA step per accept
//   ST_RESOLVE | one cycle: sreg + creg -> out_data, raise out_valid
//   ST_OUTPUT  | result held on out_valid/out_data until out_ready
//
// Ports:
//   clk, nreset         clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_data operand, in_last ends frame
//   out_valid/out_ready result handshake; out_data resolved frame sum
//   count               operands accepted this frame (saturating)
//   busy                frame open or result pending
module oh_csa_accum #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] sreg_q, sreg_d;
  logic [DW-1:0] creg_q, creg_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] count_q, count_d;

  logic [DW-1:0] maj;
  logic          accept;

  // in_ready is a pure function of state; no path from in_valid/out_ready.
  assign in_ready = (state_q == ST_ACCUM);
  assign accept   = in_valid & in_ready;
  assign maj      = (sreg_q & creg_q) | (sreg_q & in_data) | (creg_q & in_data);

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    creg_d      = creg_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;

    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          sreg_d = sreg_q ^ creg_q ^ in_data;
          // Carry moves up one bit; the carry out of the MSB is dropped,
          // which keeps the total modulo 2^DW.
          creg_d = {maj[DW-2:0], 1'b0};
          if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
          if (in_last) state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        out_data_d  = sreg_q + creg_q;
        out_valid_d = 1'b1;
        state_d     = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          // out_data is left holding the last result on purpose.
          out_valid_d = 1'b0;
          sreg_d      = '0;
          creg_d      = '0;
          count_d     = '0;
          state_d     = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= ST_ACCUM;
      sreg_q      <= '0;
      creg_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      creg_q      <= creg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_ACCUM) | (count_q != '0);

endmodule

// File: tb/tb_oh_csa_accum.sv
// Directed bench for oh_csa_accum. Three instances share one stimulus
// stream: 32-bit/CW=8 (main), 8-bit (wrap-around) and CW=2 (saturation).
module tb_oh_csa_accum;

  logic        clk = 1'b0;
  logic        nreset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        rdy32, ov32, busy32;
  logic [31:0] od32;
  logic [7:0]  cnt32;

  logic        rdy8, ov8, busy8;
  logic [7:0]  od8;
  logic [7:0]  cnt8;

  logic        rdyc2, ovc2, busyc2;
  logic [31:0] odc2;
  logic [1:0]  cntc2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  oh_csa_accum #(.DW(32), .CW(8)) u_dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy32), .out_valid(ov32), .out_data(od32),
    .out_ready(out_ready), .count(cnt32), .busy(busy32)
  );

  oh_csa_accum #(.DW(8), .CW(8)) u_dut8 (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data[7:0]),
    .in_last(in_last), .in_ready(rdy8), .out_valid(ov8), .out_data(od8),
    .out_ready(out_ready), .count(cnt8), .busy(busy8)
  );

  oh_csa_accum #(.DW(32), .CW(2)) u_dut_cw2 (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdyc2), .out_valid(ovc2), .out_data(odc2),
    .out_ready(out_ready), .count(cntc2), .busy(busyc2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat, presented for exactly one edge; the block must be ready.
  task automatic send(input logic [31:0] d, input logic last);
    check("send_rdy", 32'(rdy32), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  int t0;

  initial begin
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // reset state
    check("rst_out_valid", 32'(ov32), 32'd0);
    check("rst_out_data", od32, 32'd0);
    check("rst_count", 32'(cnt32), 32'd0);
    check("rst_busy", 32'(busy32), 32'd0);
    nreset = 1'b1;
    tick();
    check("rst_in_ready", 32'(rdy32), 32'd1);

    // 5 + 7 + 9
    send(32'd5, 1'b0);
    check("f1_busy_open", 32'(busy32), 32'd1);
    send(32'd7, 1'b0);
    send(32'd9, 1'b1);
    check("f1_resolve_ov", 32'(ov32), 32'd0);
    check("f1_resolve_rdy", 32'(rdy32), 32'd0);
    tick();
    check("f1_ov", 32'(ov32), 32'd1);
    check("f1_data", od32, 32'd21);
    check("f1_count", 32'(cnt32), 32'd3);
    tick();
    check("f1_ov_after", 32'(ov32), 32'd0);
    check("f1_rdy_after", 32'(rdy32), 32'd1);
    check("f1_data_kept", od32, 32'd21);
    check("f1_count_clr", 32'(cnt32), 32'd0);
    check("f1_busy_clr", 32'(busy32), 32'd0);

    // back-to-back single-beat frames, one result every 3 cycles
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send(32'hDEADBEEF, 1'b1);
      tick();
      check("b2b_ov", 32'(ov32), 32'd1);
      check("b2b_data", od32, 32'hDEADBEEF);
      check("b2b_count", 32'(cnt32), 32'd1);
      tick();
    end
    check("b2b_cycles", 32'(cyc - t0), 32'd12);

    // wrap-around: 8-bit instance wraps, 32-bit instance does not
    send(32'hFF, 1'b0);
    send(32'hFF, 1'b0);
    send(32'h03, 1'b1);
    tick();
    check("wrap8_data", 32'(od8), 32'h01);
    check("wrap8_ov", 32'(ov8), 32'd1);
    check("wrap32_data", od32, 32'h201);
    tick();

    // backpressure
    out_ready = 1'b0;
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    tick();
    in_valid = 1'b1;
    in_data  = 32'h55;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_ov", 32'(ov32), 32'd1);
      check("bp_data", od32, 32'd3);
      check("bp_rdy", 32'(rdy32), 32'd0);
      check("bp_count", 32'(cnt32), 32'd2);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    check("bp_release_ov", 32'(ov32), 32'd0);
    check("bp_release_cnt", 32'(cnt32), 32'd0);
    send(32'd10, 1'b1);
    tick();
    check("bp_next_data", od32, 32'd10);
    check("bp_next_count", 32'(cnt32), 32'd1);
    tick();

    // count saturation with CW=2
    for (int i = 0; i < 6; i++) send(32'd1, (i == 5));
    tick();
    check("sat_cw2_count", 32'(cntc2), 32'd3);
    check("sat_cw2_data", odc2, 32'd6);
    check("sat_cw8_count", 32'(cnt32), 32'd6);
    tick();

    // reset mid-frame
    send(32'd100, 1'b0);
    send(32'd200, 1'b0);
    nreset = 1'b0;
    tick();
    check("rmf_count", 32'(cnt32), 32'd0);
    check("rmf_busy", 32'(busy32), 32'd0);
    nreset = 1'b1;
    send(32'd4, 1'b1);
    tick();
    check("rmf_data", od32, 32'd4);
    check("rmf_count1", 32'(cnt32), 32'd1);
    tick();

    // reset during OUTPUT
    out_ready = 1'b0;
    send(32'd7, 1'b1);
    tick();
    check("rout_ov_pre", 32'(ov32), 32'd1);
    nreset = 1'b0;
    tick();
    check("rout_ov", 32'(ov32), 32'd0);
    check("rout_data", od32, 32'd0);
    check("rout_rdy", 32'(rdy32), 32'd1);
    nreset    = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
